mac_job_scheduler: RTL and testbench

Two-requester scheduler for a shared 8x8 unsigned multiply-accumulate datapath. Each requester submits a dot-product job of 1–16 operand pairs. The block arbitrates round-robin per job, streams the granted requester's operands into the MAC at up to one pair per cycle, and returns the accumulated result with a one-cycle valid pulse. It sits between the chip-level I/O front end and the MAC core, which it owns.

---
 rtl/mac_job_scheduler_pkg.sv | 18 +
 rtl/mac_job_scheduler_mac_core.sv | 57 +++++
 rtl/mac_job_scheduler.sv | 140 ++++++++++++++
 tb/tb_mac_job_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_job_scheduler_pkg.sv
// Shared constants and state encoding for the two-requester MAC job scheduler.
package mac_job_scheduler_pkg;

    localparam int OP_W      = 8;
    localparam int ACC_W_DEF = 20;
    localparam int LEN_W_DEF = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_RUN   = S_RUN,
        ST_DRAIN = S_DRAIN
    } state_t;

endpackage

// File: rtl/mac_job_scheduler_mac_core.sv
// Operand register, 8x8 multiplier and accumulator; a product is added exactly once,
// one cycle after its operands are loaded.
module mac_core
    import mac_job_scheduler_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             op_load,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] pend_prod
);

    logic [OP_W-1:0]   a_reg;
    logic [OP_W-1:0]   b_reg;
    logic              pend_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [2*OP_W-1:0] prod;

    assign prod = a_reg * b_reg;
    // Zero when nothing is pending, so stalled cycles never re-add the last product.
    assign pend_prod = pend_reg ? ACC_W'(prod) : '0;
    assign acc       = acc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            pend_reg <= 1'b0;
            acc_reg  <= '0;
        end else begin
            if (op_load) begin
                a_reg <= a;
                b_reg <= b;
            end
            if (clr) begin
                acc_reg  <= '0;
                pend_reg <= 1'b0;
            end else begin
                if (en) begin
                    acc_reg <= acc_reg + pend_prod;
                end
                if (op_load) begin
                    pend_reg <= 1'b1;
                end else if (en) begin
                    pend_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mac_job_scheduler.sv
// Round-robin job scheduler in front of a shared MAC: arbitrates per job, streams
// the winner's operand pairs and returns the dot product with a one-cycle pulse.
module mac_job_scheduler
    import mac_job_scheduler_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] req_len0,
    input  logic [LEN_W-1:0] req_len1,
    input  logic [OP_W-1:0]  a0,
    input  logic [OP_W-1:0]  b0,
    input  logic [OP_W-1:0]  a1,
    input  logic [OP_W-1:0]  b1,
    input  logic [1:0]       op_valid,
    output logic [1:0]       op_ready,
    output logic [1:0]       gnt,
    output logic [1:0]       res_valid,
    output logic [ACC_W-1:0] res_data,
    output logic             busy
);

    state_t           state_reg, state_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic [LEN_W-1:0] beats_left_reg, beats_left_next;
    logic             last_reg, last_next;
    logic [ACC_W-1:0] res_data_reg, res_data_next;
    logic [1:0]       res_valid_reg, res_valid_next;

    logic             win;
    logic             xfer;
    logic             clr;
    logic             en;
    logic [OP_W-1:0]  a_sel;
    logic [OP_W-1:0]  b_sel;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] pend_prod;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign op_ready[gi] = (state_reg == ST_RUN) && gnt_reg[gi];
        end
    endgenerate

    assign gnt       = gnt_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;

    assign xfer  = |(op_valid & op_ready);
    assign en    = (state_reg != ST_IDLE);
    assign a_sel = gnt_reg[1] ? a1 : a0;
    assign b_sel = gnt_reg[1] ? b1 : b0;

    mac_core #(
        .ACC_W (ACC_W)
    ) u_mac_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (en),
        .op_load   (xfer),
        .a         (a_sel),
        .b         (b_sel),
        .acc       (acc),
        .pend_prod (pend_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            gnt_reg        <= '0;
            beats_left_reg <= '0;
            last_reg       <= 1'b1;
            res_data_reg   <= '0;
            res_valid_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            gnt_reg        <= gnt_next;
            beats_left_reg <= beats_left_next;
            last_reg       <= last_next;
            res_data_reg   <= res_data_next;
            res_valid_reg  <= res_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        gnt_next        = gnt_reg;
        beats_left_next = beats_left_reg;
        last_next       = last_reg;
        res_data_next   = res_data_reg;
        res_valid_next  = '0;
        clr             = 1'b0;
        win             = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Contention goes to the requester not served last; a lone requester always wins.
                if (req == 2'b11) begin
                    win = ~last_reg;
                end else begin
                    win = req[1];
                end
                if (req != 2'b00) begin
                    gnt_next        = win ? 2'b10 : 2'b01;
                    beats_left_next = win ? req_len1 : req_len0;
                    clr             = 1'b1;
                    state_next      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (beats_left_reg == '0) begin
                        state_next = ST_DRAIN;
                    end else begin
                        beats_left_next = beats_left_reg - LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Last product is still in the operand stage; fold it in here.
                res_data_next  = acc + pend_prod;
                res_valid_next = gnt_reg;
                last_next      = gnt_reg[1];
                gnt_next       = '0;
                state_next     = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mac_job_scheduler.sv
// Randomized bench for mac_job_scheduler against a job-level reference model.
module tb_mac_job_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [3:0]  req_len0, req_len1;
    logic [7:0]  a0, b0, a1, b1;
    logic [1:0]  op_valid;
    logic [1:0]  op_ready;
    logic [1:0]  gnt;
    logic [1:0]  res_valid;
    logic [19:0] res_data;
    logic        busy;

    mac_job_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_len0  (req_len0),
        .req_len1  (req_len1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester side: 0 = quiet, 1 = requesting, 2 = granted / job in flight
    int         rq_state[2];
    int         rq_wait[2];
    int         rq_len[2];
    int         rq_idx[2];
    int         rq_gold[2];
    int         vprob[2];
    bit         drop_req[2];
    logic [7:0] rq_a[2][16];
    logic [7:0] rq_b[2][16];
    bit         rand_en = 0;
    bit         vpat[$];
    int         vpat_req = 0;

    // Job-level reference model
    int         m_owner = -1;
    int         m_left = 0;
    int         m_sum = 0;
    int         m_res_edge = -1;
    int         m_last = 1;
    int         m_res_data = 0;
    int         edge_no = 0;
    int         jobs_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic new_random_job(input int r);
        rq_len[r] = ($urandom_range(3) == 0) ? 15 : int'($urandom_range(15));
        for (int i = 0; i < 16; i++) begin
            rq_a[r][i] = ($urandom_range(9) == 0) ? 8'hFF : 8'($urandom);
            rq_b[r][i] = ($urandom_range(9) == 0) ? 8'hFF : 8'($urandom);
        end
        rq_gold[r]  = 0;
        rq_idx[r]   = 0;
        rq_state[r] = 1;
    endtask

    task automatic drive();
        for (int r = 0; r < 2; r++) begin
            logic       rq, v;
            logic [3:0] ln;
            logic [7:0] aa, bb;
            if (rq_state[r] == 0 && rand_en) begin
                if (rq_wait[r] > 0) rq_wait[r]--;
                else new_random_job(r);
            end
            rq = (rq_state[r] == 1) || (rq_state[r] == 2 && !drop_req[r]);
            ln = (rq_state[r] == 1) ? 4'(rq_len[r]) : 4'($urandom_range(15));
            if (rq_state[r] != 0 && rq_idx[r] <= rq_len[r]) begin
                aa = rq_a[r][rq_idx[r]];
                bb = rq_b[r][rq_idx[r]];
            end else begin
                aa = 8'($urandom);
                bb = 8'($urandom);
            end
            if (rq_state[r] == 2 && r == vpat_req && vpat.size() > 0) v = vpat.pop_front();
            else v = ($urandom_range(99) < vprob[r]);
            if (r == 0) begin
                req[0] = rq; req_len0 = ln; a0 = aa; b0 = bb; op_valid[0] = v;
            end else begin
                req[1] = rq; req_len1 = ln; a1 = aa; b1 = bb; op_valid[1] = v;
            end
        end
    endtask

    // One clock: advance the model over the edge, compare all outputs, drive next inputs.
    task automatic cycle();
        int drained_to;
        int gold;
        int w;
        drained_to = -1;
        gold = 0;
        @(posedge clk);
        edge_no++;
        if (m_owner >= 0 && m_left > 0) begin
            if (op_valid[m_owner]) begin
                m_sum += int'(rq_a[m_owner][rq_idx[m_owner]]) * int'(rq_b[m_owner][rq_idx[m_owner]]);
                rq_idx[m_owner]++;
                m_left--;
                if (m_left == 0) m_res_edge = edge_no + 1;
            end
        end else if (m_owner >= 0) begin
            if (edge_no == m_res_edge) begin
                drained_to = m_owner;
                gold = rq_gold[m_owner];
                m_res_data = m_sum;
                m_last = m_owner;
                rq_state[m_owner] = 0;
                rq_wait[m_owner] = int'($urandom_range(5));
                m_owner = -1;
                jobs_done++;
            end
        end else if (req != 2'b00) begin
            if (req == 2'b11) w = 1 - m_last;
            else w = req[1] ? 1 : 0;
            m_owner = w;
            m_left = rq_len[w] + 1;
            m_sum = 0;
            rq_state[w] = 2;
            rq_idx[w] = 0;
            drop_req[w] = rand_en && ($urandom_range(1) == 1);
        end
        #1;
        check("gnt", 32'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
        check("op_ready", 32'(op_ready), (m_owner >= 0 && m_left > 0) ? (1 << m_owner) : 0);
        check("busy", 32'(busy), (m_owner >= 0) ? 1 : 0);
        check("res_valid", 32'(res_valid), (drained_to >= 0) ? (1 << drained_to) : 0);
        check("res_data", 32'(res_data), m_res_data);
        if (drained_to >= 0) begin
            $display("job %0d: requester %0d, %0d pairs, result %0d (dut %0d)",
                     jobs_done, drained_to, rq_len[drained_to] + 1, m_res_data, res_data);
            if (gold != 0) check("golden", 32'(res_data), gold);
        end
        drive();
    endtask

    task automatic load_job(input int r, input int len, input int gold);
        rq_len[r]   = len;
        rq_gold[r]  = gold;
        rq_idx[r]   = 0;
        rq_state[r] = 1;
        drive();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((m_owner >= 0 || rq_state[0] != 0 || rq_state[1] != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("idle_busy", 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_op_ready"}, 32'(op_ready), 0);
        check({tag, "_res_valid"}, 32'(res_valid), 0);
        check({tag, "_res_data"}, 32'(res_data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        int n;
        for (int r = 0; r < 2; r++) begin
            rq_state[r] = 0; rq_wait[r] = 0; rq_len[r] = 0; rq_idx[r] = 0;
            rq_gold[r] = 0; vprob[r] = 100; drop_req[r] = 0;
        end
        rst_n = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Contention right after reset: requester 0 first, then 1
        rq_a[0][0] = 8'd2; rq_b[0][0] = 8'd3;
        rq_a[1][0] = 8'd7; rq_b[1][0] = 8'd7;
        rq_state[0] = 1; rq_len[0] = 0; rq_gold[0] = 6;  rq_idx[0] = 0;
        load_job(1, 0, 49);
        run_until_idle(50);

        // Single 3-pair job while the other requester holds op_valid high
        for (int i = 0; i < 3; i++) begin
            rq_a[0][i] = 8'(i + 1);
            rq_b[0][i] = 8'(i + 4);
        end
        vprob[1] = 100;
        load_job(0, 2, 32);
        run_until_idle(50);

        // Max-length job of 255*255
        for (int i = 0; i < 16; i++) begin
            rq_a[1][i] = 8'hFF;
            rq_b[1][i] = 8'hFF;
        end
        vprob[0] = 100;
        load_job(1, 15, 1040400);
        run_until_idle(60);

        // Stalled job: valid pattern 1,0,0,1,1,0,1 gives four accepts
        for (int i = 0; i < 4; i++) begin
            rq_a[0][i] = 8'(i + 1);
            rq_b[0][i] = 8'(i + 1);
        end
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vpat_req = 0;
        load_job(0, 3, 30);
        run_until_idle(60);
        vpat.delete();

        // Random traffic from both requesters
        rand_en = 1;
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) begin
                vprob[0] = int'($urandom_range(30, 100));
                vprob[1] = int'($urandom_range(30, 100));
            end
            cycle();
        end
        rand_en = 0;
        run_until_idle(200);

        // Reset in the middle of a 5-beat job
        vprob[0] = 100;
        for (int i = 0; i < 5; i++) begin
            rq_a[0][i] = 8'(10 + i);
            rq_b[0][i] = 8'(20 + i);
        end
        load_job(0, 4, 0);
        n = 0;
        while (rq_idx[0] < 2 && n < 20) begin
            cycle();
            n++;
        end
        check("mid_job_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_owner = -1; m_left = 0; m_sum = 0; m_res_edge = -1; m_last = 1; m_res_data = 0;
        rq_state[0] = 0; rq_state[1] = 0;
        drive();
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        rst_n = 1'b1;

        // Fresh job after reset
        rq_a[1][0] = 8'd10; rq_b[1][0] = 8'd20;
        rq_a[1][1] = 8'd30; rq_b[1][1] = 8'd40;
        load_job(1, 1, 1400);
        run_until_idle(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
